sincn_decimator: RTL and testbench
==================================

// Module: sincn_decimator
// PURPOSE
//  Parametrised CIC (sinc^N) decimator for 1-bit PDM microphone data; generalises the fixed sinc3/8-bit stage.
//  Adds configurable order, rate and output width, plus start-up settling suppression, output saturation,
//  a valid/ready output handshake with overrun flag, and a soft enable. Sits between the PDM pin sampler and audio FIFO.
// PARAMETERS
//  ORDER     3   filter order N, legal 1..5
//  DEC_RATE  64  decimation ratio R, legal 2..1024
//  OUT_W     16  output width, legal 2..ACC_W-1
//  (derived) ACC_W = ORDER*$clog2(DEC_RATE)+1; SHIFT = ACC_W-1-OUT_W
// PORTS
//  mclk1        in   1      PDM bit clock; all logic on posedge
//  reset_n      in   1      asynchronous active-low reset
//  en           in   1      filter enable; low = soft clear
//  mdata1       in   1      PDM bit, sampled every mclk1 while en=1
//  out_data     out  OUT_W  decimated unsigned sample
//  out_valid    out  1      out_data holds an unconsumed sample
//  out_ready    in   1      consumer accepts when out_valid&&out_ready
//  out_overrun  out  1      1-cycle pulse: unconsumed sample overwritten
// BEHAVIOUR
//  Reset (reset_n=0, async): all integrators, comb delays, counters = 0; out_data=0, out_valid=0, out_overrun=0.
//  Integrators: ORDER cascaded ACC_W-bit accumulators, I1 += mdata1 (0/1), Ik += I(k-1); modulo-2^ACC_W wrap is intended.
//  Sample counter 0..DEC_RATE-1; wraps to 0; "tick" = cycle where counter==DEC_RATE-1 and en=1.
//  On tick: comb chain evaluated on updated I_ORDER; each stage Ck = C(k-1) - C(k-1)_delayed; delays updated; all ACC_W-bit.
//  Result Y (0..DEC_RATE^ORDER) scaled: S = Y >> SHIFT; if S > 2^OUT_W-1 then S = 2^OUT_W-1 (saturate, full-scale power-of-2 R).
//  Latency: out_data/out_valid update on the mclk1 edge after the tick cycle; one sample per DEC_RATE cycles.
//  Settling: first ORDER ticks after reset or after en rises are discarded (combs unfilled); settle counter 0..ORDER saturates.
//  Handshake: out_valid cleared on cycle after out_valid&&out_ready; out_data stable while out_valid=1 and no new sample.
//  New sample while out_valid=1 and out_ready=0: out_data overwritten, out_valid stays 1, out_overrun=1 for one cycle.
//  New sample same cycle as accept (out_valid&&out_ready): old consumed, new loaded, out_valid stays 1, no overrun.
//  en=0: synchronous clear of integrators, combs, sample and settle counters; out_valid=0; out_data holds last value; no ticks.
//  en deasserted mid-frame: partial frame discarded; en re-assert restarts counter at 0 and the settle period.
//  Parameters outside legal ranges: elaboration-time $error.
// CONFIGURATION
//  SINCN_ROUND_EN defined: S = (Y + 2^(SHIFT-1)) >> SHIFT (round-half-up), computed in ACC_W+1 bits, then saturate;
//    when SHIFT=0 no rounding term added.
//  SINCN_ROUND_EN undefined: plain truncation S = Y >> SHIFT, then saturate.
// TESTING (ORDER=3, DEC_RATE=64, OUT_W=16 -> ACC_W=19, SHIFT=2 unless stated)
//  1. mdata1=1 constant, out_ready=1 -> no out_valid for first 3 ticks; from 4th: out_data=16'hFFFF (65536 saturated).
//  2. mdata1=0 constant -> after settling out_data=0 every 64 cycles; out_overrun never asserts.
//  3. mdata1 alternating 1,0 -> settled out_data=16'h8000 (Y=131072); rounding build gives same value.
//  4. Hold out_ready=0 across two settled samples -> out_overrun pulses once at 2nd, out_data = 2nd sample, out_valid=1.
//  5. Drop en for 10 cycles mid-frame, re-raise -> out_valid=0 immediately after, next valid only after 3 discarded ticks.
//  6. Assert reset_n=0 asynchronously mid-frame -> outputs 0 at once without clock edge; restart matches scenario 1 timing.

Source files
------------

// File: rtl/sincn_decimator.sv
// CIC (sinc^N) decimator for 1-bit PDM data with settling suppression, saturation and valid/ready output.
// Optional SINCN_ROUND_EN: round-half-up before saturation instead of plain truncation.
module sincn_decimator #(
  parameter int ORDER    = 3,
  parameter int DEC_RATE = 64,
  parameter int OUT_W    = 16
) (
  input  logic             mclk1,
  input  logic             reset_n,
  input  logic             en,
  input  logic             mdata1,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_overrun
);

  localparam int ACC_W = ORDER * $clog2(DEC_RATE) + 1;
  localparam int SHIFT = ACC_W - 1 - OUT_W;
  localparam int CNT_W = $clog2(DEC_RATE);
  localparam int SET_W = $clog2(ORDER + 1);

  if (ORDER < 1 || ORDER > 5) begin : g_bad_order
    $error("sincn_decimator: ORDER %0d outside 1..5", ORDER);
  end
  if (DEC_RATE < 2 || DEC_RATE > 1024) begin : g_bad_rate
    $error("sincn_decimator: DEC_RATE %0d outside 2..1024", DEC_RATE);
  end
  if (OUT_W < 2 || OUT_W > ACC_W - 1) begin : g_bad_outw
    $error("sincn_decimator: OUT_W %0d outside 2..%0d", OUT_W, ACC_W - 1);
  end

  logic [CNT_W-1:0] cnt;
  logic [SET_W-1:0] settle;
  logic             tick;
  logic             emit;
  logic [ACC_W-1:0] comb_in;
  logic [ACC_W-1:0] y_full;

  assign tick = en && (cnt == CNT_W'(DEC_RATE - 1));
  assign emit = tick && (settle == SET_W'(ORDER));

  always_ff @(posedge mclk1 or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      settle <= '0;
    end else if (!en) begin
      cnt    <= '0;
      settle <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick && settle != SET_W'(ORDER)) settle <= settle + SET_W'(1);
    end
  end

  // Integrator k sums the registered output of stage k-1, so no long adder chain forms.
  for (genvar k = 0; k < ORDER; k++) begin : g_int
    logic [ACC_W-1:0] acc, acc_nxt, src;
    if (k == 0) begin : g_src0
      assign src = {{(ACC_W-1){1'b0}}, mdata1};
    end else begin : g_srck
      assign src = g_int[k-1].acc;
    end
    assign acc_nxt = acc + src;
    always_ff @(posedge mclk1 or negedge reset_n) begin
      if (!reset_n)  acc <= '0;
      else if (!en)  acc <= '0;
      else           acc <= acc_nxt;
    end
  end

  assign comb_in = g_int[ORDER-1].acc_nxt;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    logic [ACC_W-1:0] x, dly, y;
    if (k == 0) begin : g_x0
      assign x = comb_in;
    end else begin : g_xk
      assign x = g_comb[k-1].y;
    end
    assign y = x - dly;
    always_ff @(posedge mclk1 or negedge reset_n) begin
      if (!reset_n)  dly <= '0;
      else if (!en)  dly <= '0;
      else if (tick) dly <= x;
    end
  end

  assign y_full = g_comb[ORDER-1].y;

  // Extra top bit keeps the rounding carry of a full-scale result.
  logic [ACC_W:0] y_ext, y_rnd, s_shift;
  logic [OUT_W-1:0] sample;
  localparam logic [ACC_W:0] S_MAX = {{(ACC_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  assign y_ext = {1'b0, y_full};
`ifdef SINCN_ROUND_EN
  if (SHIFT > 0) begin : g_rnd
    assign y_rnd = y_ext + ((ACC_W+1)'(1) << (SHIFT - 1));
  end else begin : g_nornd
    assign y_rnd = y_ext;
  end
`else
  assign y_rnd = y_ext;
`endif
  assign s_shift = y_rnd >> SHIFT;
  assign sample  = (s_shift > S_MAX) ? {OUT_W{1'b1}} : s_shift[OUT_W-1:0];

  always_ff @(posedge mclk1 or negedge reset_n) begin
    if (!reset_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_overrun <= 1'b0;
    end else if (!en) begin
      out_valid   <= 1'b0;
      out_overrun <= 1'b0;
    end else if (emit) begin
      out_data    <= sample;
      out_valid   <= 1'b1;
      out_overrun <= out_valid && !out_ready;
    end else begin
      out_overrun <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sincn_decimator.sv
// Table-driven bench for sincn_decimator (ORDER=3, DEC_RATE=64, OUT_W=16) with a sample scoreboard.
module tb_sincn_decimator;

  localparam int R = 64;

  logic        mclk1 = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        mdata1 = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_overrun;

  always #5 mclk1 = ~mclk1;

  sincn_decimator #(.ORDER(3), .DEC_RATE(R), .OUT_W(16)) dut (
    .mclk1(mclk1), .reset_n(reset_n), .en(en), .mdata1(mdata1),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_overrun(out_overrun)
  );

  typedef struct {
    int          pat;   // 0: all zeros, 1: all ones, 2: alternating 1,0
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[4];
  logic [15:0] sb[$];
  logic [15:0] sb_exp;
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  bit          push_en = 1'b0;
  int          cyc = 0;
  int          pat = 0;
  logic [15:0] pat_exp = '0;
  logic [15:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pat_bit(input int p, input int c);
    case (p)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return (c % 2) == 0;
    endcase
  endfunction

  // Drives one PDM bit per cycle; cyc models the sample position since en rose.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mdata1 = pat_bit(pat, cyc);
      if (push_en && en && reset_n && (cyc % R) == R - 1 && (cyc / R) >= 3)
        sb.push_back(pat_exp);
      @(posedge mclk1);
      cyc = (en && reset_n) ? cyc + 1 : 0;
      #1;
    end
  endtask

  always @(negedge mclk1) begin
    if (mon_en && reset_n && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_sample: got sample %0h, expected none yet (t=%0t)", out_data, $time);
      end else begin
        sb_exp = sb.pop_front();
        chk("sample", out_data, sb_exp);
        chk("no_overrun", out_overrun, 0);
      end
    end
  end

  initial begin
    vecs[0] = '{1, 16'hFFFF};
    vecs[1] = '{0, 16'h0000};
    vecs[2] = '{2, 16'h8000};
    vecs[3] = '{1, 16'hFFFF};

    #12;
    chk("reset_data", out_data, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_overrun", out_overrun, 0);
    @(posedge mclk1); #1;
    reset_n = 1'b1;
    cyc = 0;

    mon_en = 1'b1;
    push_en = 1'b1;
    last_data = '0;
    for (int v = 0; v < 4; v++) begin
      pat = vecs[v].pat;
      pat_exp = vecs[v].exp;
      en = 1'b0;
      run_cycles(1);
      chk("en_low_valid", out_valid, 0);
      chk("en_low_hold", out_data, last_data);
      run_cycles(9);
      en = 1'b1;
      run_cycles(6 * R + 2);
      chk("samples_seen", sb.size(), 0);
      last_data = vecs[v].exp;
    end

    // Overrun and simultaneous accept+load
    mon_en = 1'b0;
    push_en = 1'b0;
    pat = 2;
    en = 1'b0;
    run_cycles(2);
    en = 1'b1;
    out_ready = 1'b0;
    run_cycles(4 * R);
    chk("ovr_first_valid", out_valid, 1);
    chk("ovr_first_flag", out_overrun, 0);
    chk("ovr_first_data", out_data, 16'h8000);
    run_cycles(R - 1);
    chk("ovr_wait_flag", out_overrun, 0);
    chk("ovr_wait_valid", out_valid, 1);
    run_cycles(1);
    chk("ovr_pulse", out_overrun, 1);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_data", out_data, 16'h8000);
    run_cycles(1);
    chk("ovr_pulse_end", out_overrun, 0);
    chk("ovr_valid_held", out_valid, 1);
    run_cycles(R - 2);
    out_ready = 1'b1;
    run_cycles(1);
    chk("acc_load_valid", out_valid, 1);
    chk("acc_load_noovr", out_overrun, 0);
    run_cycles(1);
    chk("acc_cleared", out_valid, 0);

    // Asynchronous reset with a sample pending
    out_ready = 1'b0;
    en = 1'b0;
    run_cycles(2);
    en = 1'b1;
    pat = 1;
    run_cycles(4 * R);
    chk("pre_reset_valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_data", out_data, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_overrun", out_overrun, 0);
    @(posedge mclk1); #1;
    reset_n = 1'b1;
    cyc = 0;
    sb.delete();
    out_ready = 1'b1;
    pat_exp = 16'hFFFF;
    mon_en = 1'b1;
    push_en = 1'b1;
    run_cycles(6 * R + 2);
    chk("post_reset_samples", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
